logic_74hc259_driver: RTL and testbench
=======================================

// Module: logic_74hc259_driver
// PURPOSE
//  Bus-side initiator for an external 74HC259 8-bit addressable latch.
//  Accepts a parallel byte via valid/ready and writes it into the latch one bit
//  at a time over the A/D/nLE/nMR pins, with programmable setup/strobe/hold.
//  Keeps a shadow copy of the latch contents and skips bits that are unchanged.
//  Sits between emulator register logic and the latch pin model or board pins.
// PARAMETERS
//  SETUP_CYC  1  cycles A/D stable with nLE high before the strobe (>=1)
//  PULSE_CYC  1  cycles nLE (write) or nMR (clear) held low (>=1)
//  HOLD_CYC   1  cycles A/D held with nLE high after the strobe (>=1)
//  SKIP_SAME  1  1: write only bits differing from the shadow; 0: write all 8
// PORTS
//  CLK        in   1  system clock, rising edge
//  nRST       in   1  asynchronous active-low reset
//  WR_VALID   in   1  write request; WR_DATA is valid
//  WR_DATA    in   8  byte to place on latch outputs Q[7:0]
//  WR_READY   out  1  driver idle; write or clear can be accepted
//  CLR_REQ    in   1  clear request; takes priority over WR_VALID
//  A          out  3  latch address pins
//  D          out  1  latch data pin
//  nLE        out  1  latch enable, active low
//  nMR        out  1  latch master reset, active low
//  SHADOW     out  8  current latch contents as known to the driver
//  BUSY       out  1  equals ~WR_READY
// BEHAVIOUR
//  - Reset (async): A=0, D=0, nLE=1, nMR=0, SHADOW=0, WR_READY=0, state=CLEAR,
//    counter=PULSE_CYC. nMR low clears the latch, so SHADOW=0 stays consistent.
//  - All pin outputs are registered. nLE and nMR are never low in the same cycle.
//  - States:
//    - CLEAR: nMR=0 for PULSE_CYC cycles, then SHADOW<=0 and go to IDLE.
//    - IDLE: WR_READY=1, nLE=1, nMR=1.
//      - CLR_REQ=1 -> CLEAR (write not accepted the same cycle).
//      - Else WR_VALID=1 -> capture WR_DATA into DREG, idx<=0, go to SCAN.
//    - SCAN (1 cycle per bit):
//      - If SKIP_SAME=0 or DREG[idx]!=SHADOW[idx]: A<=idx, D<=DREG[idx] -> SETUP.
//      - Else if idx==7 -> IDLE; otherwise idx<=idx+1 and stay in SCAN.
//    - SETUP: nLE=1 for SETUP_CYC cycles -> STROBE.
//    - STROBE: nLE=0 for PULSE_CYC cycles. On exit, nLE<=1, SHADOW[idx]<=D -> HOLD.
//    - HOLD: nLE=1, A/D unchanged, for HOLD_CYC cycles.
//      - idx==7 -> IDLE; otherwise idx<=idx+1 -> SCAN.
//  - A and D change only on entry to SETUP, never while nLE=0.
//  - Latency: from acceptance edge to WR_READY=1 takes 8+N*(SETUP_CYC+PULSE_CYC+
//    HOLD_CYC) cycles, where N = number of bits written (0..8).
//  - An all-equal byte with SKIP_SAME=1 costs 8 cycles and produces no nLE pulse.
//  - WR_VALID and CLR_REQ are ignored while BUSY; there is no queueing.
//  - CLR_REQ is accepted only in IDLE. A clear costs PULSE_CYC cycles.
//  - Phase counter is a down-counter of width $clog2(max param+1); 0 ends the phase.
//  - Reset mid-write: write aborted, pins at reset values, latch cleared by nMR.
// STRUCTURE
//  - Shared include hc259_defs.vh holds:
//    - state encodings (CLEAR, IDLE, SCAN, SETUP, STROBE, HOLD);
//    - the counter-width constant function.
//  - Optional sub-module hc259_phase_timer: loadable down-counter with a
//    done flag; all other logic sits inline in the FSM.
// TESTING
//  - Bench has a behavioural latch model sampling pins and compares model Q
//    to SHADOW after every transaction.
//  1. Reset release, params 1/1/1:
//     -> nMR=0 for 1 cycle after reset; WR_READY=1 on 2nd cycle; SHADOW=8'h00.
//  2. Write 8'hA5 from 8'h00, 1/1/1:
//     -> 4 nLE pulses at A=0,2,5,7 with D=1; BUSY for 8+4*3=20 cycles;
//     -> SHADOW=8'hA5.
//  3. Write 8'hA5 again: no nLE pulse, BUSY for 8 cycles.
//     Then write 8'h5A: 8 pulses, 32 cycles.
//  4. SKIP_SAME=0, params 2/3/1, write 8'hFF:
//     -> 8 pulses, each nLE low 3 cycles; A/D stable 2 before / 1 after each pulse.
//  5. CLR_REQ and WR_VALID together in IDLE:
//     -> clear only; WR_READY stays low; SHADOW=8'h00; data not captured.
//  6. Assert nRST during 3rd STROBE of a write:
//     -> outputs at reset values immediately; model Q=8'h00 after release.

Source files
------------

// File: rtl/logic_74hc259_driver_pkg.sv
// Shared definitions for the 74HC259 addressable-latch driver: FSM state
// encodings and the width helper for the phase down-counter.
package logic_74hc259_driver_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,  // nMR held low, latch being cleared
    ST_IDLE   = 3'd1,  // ready for a write or clear
    ST_SCAN   = 3'd2,  // one cycle per bit: decide whether to write it
    ST_SETUP  = 3'd3,  // A/D settled, nLE still high
    ST_STROBE = 3'd4,  // nLE low, latch transparent for the addressed bit
    ST_HOLD   = 3'd5   // nLE back high, A/D held
  } state_e;

  localparam int unsigned NUM_BITS = 8;

  // Width of a down-counter that must hold the largest of the three phase
  // lengths. Always at least one bit wide.
  function automatic int cnt_width(input int setup_cyc, input int pulse_cyc,
                                   input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/logic_74hc259_driver_timer.sv
// Loadable phase down-counter. A phase loaded with value N lasts N cycles:
// done_o is high in the cycle whose decrement takes the count to zero.
module logic_74hc259_driver_timer #(
  parameter int W       = 1,
  parameter int RST_VAL = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and rest at zero.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register; after reset it already holds the first clear phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples its inputs from the same pre-edge values.
    if (!rst_ni) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/logic_74hc259_driver.sv
// Bus-side initiator for an external 74HC259 addressable latch. A byte taken
// over valid/ready is written into the latch one bit at a time over the
// A/D/nLE pins; nMR clears it. A shadow copy of the latch lets unchanged bits
// be skipped. All pin outputs come straight from flops.
module logic_74hc259_driver
  import logic_74hc259_driver_pkg::*;
#(
  parameter int SETUP_CYC = 1,  // A/D stable, nLE high, before the strobe
  parameter int PULSE_CYC = 1,  // nLE (write) or nMR (clear) low time
  parameter int HOLD_CYC  = 1,  // A/D held, nLE high, after the strobe
  parameter int SKIP_SAME = 1   // 1: only write bits that differ from shadow
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       WR_VALID,
  input  logic [7:0] WR_DATA,
  output logic       WR_READY,
  input  logic       CLR_REQ,
  output logic [2:0] A,
  output logic       D,
  output logic       nLE,
  output logic       nMR,
  output logic [7:0] SHADOW,
  output logic       BUSY
);

  localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  state_e     state_q;
  logic [2:0] a_q;
  logic       d_q;
  logic       nle_q;
  logic       nmr_q;
  logic       ready_q;
  logic [7:0] shadow_q;
  logic [7:0] dreg_q;
  logic [2:0] idx_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             bit_needs_write;

  // A bit is written when skipping is disabled or the latch disagrees.
  assign bit_needs_write = (SKIP_SAME == 0) || (dreg_q[idx_q] != shadow_q[idx_q]);

  // Start the next timed phase on the edge that enters it.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (CLR_REQ) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PULSE_CYC);
        end
      end
      ST_SCAN: begin
        if (bit_needs_write) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PULSE_CYC);
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC);
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  logic_74hc259_driver_timer #(
    .W      (CNT_W),
    .RST_VAL(PULSE_CYC)
  ) u_timer (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  // Main sequencer: walks the byte bit by bit and drives the latch pins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // nMR low at reset clears the external latch, matching shadow_q = 0.
      state_q  <= ST_CLEAR;
      a_q      <= 3'd0;
      d_q      <= 1'b0;
      nle_q    <= 1'b1;
      nmr_q    <= 1'b0;
      ready_q  <= 1'b0;
      shadow_q <= 8'h00;
      dreg_q   <= 8'h00;
      idx_q    <= 3'd0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          if (tmr_done) begin
            nmr_q    <= 1'b1;
            shadow_q <= 8'h00;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          // A clear wins; a write offered alongside it is dropped.
          if (CLR_REQ) begin
            nmr_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_CLEAR;
          end else if (WR_VALID) begin
            dreg_q  <= WR_DATA;
            idx_q   <= 3'd0;
            ready_q <= 1'b0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bit_needs_write) begin
            // A/D only ever change here, well before nLE can fall.
            a_q     <= idx_q;
            d_q     <= dreg_q[idx_q];
            state_q <= ST_SETUP;
          end else if (idx_q == 3'd7) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            nle_q   <= 1'b0;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            nle_q           <= 1'b1;
            shadow_q[idx_q] <= d_q;
            state_q         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (idx_q == 3'd7) begin
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_SCAN;
            end
          end
        end
        default: begin
          nle_q   <= 1'b1;
          nmr_q   <= 1'b0;
          ready_q <= 1'b0;
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign A        = a_q;
  assign D        = d_q;
  assign nLE      = nle_q;
  assign nMR      = nmr_q;
  assign SHADOW   = shadow_q;
  assign WR_READY = ready_q;
  assign BUSY     = ~ready_q;

endmodule

// File: tb/tb_logic_74hc259_driver.sv
// Bench for logic_74hc259_driver. Two instances: dut_a (1/1/1, skip unchanged)
// and dut_b (2/3/1, write all bits). Stimulus pushes the expected outcome of
// each transaction; a negedge monitor drives a behavioural 74HC259 model from
// the pins, checks pin timing, and compares when BUSY drops.
module tb_logic_74hc259_driver;

  typedef struct {
    logic [7:0] shadow;  // final SHADOW and model Q
    int         busy;    // cycles BUSY stays high
    int         pulses;  // nLE pulses seen
    logic [7:0] amask;   // addresses strobed
    logic [7:0] dmask;   // addresses strobed with D=1
  } exp_t;

  logic       clk;
  logic       nrst     [2];
  logic       wr_valid [2];
  logic [7:0] wr_data  [2];
  logic       clr_req  [2];
  logic       wr_ready [2];
  logic [2:0] a_s      [2];
  logic       d_s      [2];
  logic       nle_s    [2];
  logic       nmr_s    [2];
  logic [7:0] shadow_s [2];
  logic       busy_s   [2];
  logic [7:0] model_q  [2];

  int n_pass  = 0;
  int n_total = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // monitor state, one slot per DUT
  int         busy_cnt   [2];
  int         pulses     [2];
  int         terr       [2];
  int         low_run    [2];
  int         stable_cnt [2];
  int         hold_cnt   [2];
  logic       in_hold    [2];
  logic [7:0] amask      [2];
  logic [7:0] dmask      [2];
  logic [2:0] prev_a     [2];
  logic       prev_d     [2];
  logic       prev_nle   [2];

  logic_74hc259_driver #(
    .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .SKIP_SAME(1)
  ) dut_a (
    .CLK(clk), .nRST(nrst[0]), .WR_VALID(wr_valid[0]), .WR_DATA(wr_data[0]),
    .WR_READY(wr_ready[0]), .CLR_REQ(clr_req[0]), .A(a_s[0]), .D(d_s[0]),
    .nLE(nle_s[0]), .nMR(nmr_s[0]), .SHADOW(shadow_s[0]), .BUSY(busy_s[0])
  );

  logic_74hc259_driver #(
    .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1), .SKIP_SAME(0)
  ) dut_b (
    .CLK(clk), .nRST(nrst[1]), .WR_VALID(wr_valid[1]), .WR_DATA(wr_data[1]),
    .WR_READY(wr_ready[1]), .CLR_REQ(clr_req[1]), .A(a_s[1]), .D(d_s[1]),
    .nLE(nle_s[1]), .nMR(nmr_s[1]), .SHADOW(shadow_s[1]), .BUSY(busy_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s_of(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int p_of(input int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int h_of(input int k); return 1; endfunction
  function automatic string tag_of(input int k); return (k == 0) ? "a" : "b"; endfunction

  function automatic exp_t mk(input logic [7:0] sh, input int busy, input int pulses,
                              input logic [7:0] am, input logic [7:0] dm);
    exp_t e;
    e.shadow = sh;
    e.busy   = busy;
    e.pulses = pulses;
    e.amask  = am;
    e.dmask  = dm;
    return e;
  endfunction

  // 74HC259 truth table: clear / demux / addressable latch / hold.
  function automatic logic [7:0] latch_next(input logic [7:0] q, input logic [2:0] a,
                                            input logic d, input logic nle,
                                            input logic nmr);
    logic [7:0] n;
    n = q;
    if (!nmr && nle) begin
      n = 8'h00;
    end else if (!nmr && !nle) begin
      n    = 8'h00;
      n[a] = d;
    end else if (!nle) begin
      n[a] = d;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_reset(input int k);
    busy_cnt[k]   = 0;
    pulses[k]     = 0;
    terr[k]       = 0;
    low_run[k]    = 0;
    stable_cnt[k] = 0;
    hold_cnt[k]   = 0;
    in_hold[k]    = 1'b0;
    amask[k]      = 8'h00;
    dmask[k]      = 8'h00;
    prev_a[k]     = a_s[k];
    prev_d[k]     = d_s[k];
    prev_nle[k]   = 1'b1;
  endtask

  task automatic mon_step(input int k);
    logic ad_chg;
    exp_t e;
    int   avail;
    string t;
    t = tag_of(k);
    if (!nrst[k]) begin
      mon_reset(k);
      return;
    end
    ad_chg = (a_s[k] != prev_a[k]) || (d_s[k] != prev_d[k]);
    if (!nle_s[k] && !nmr_s[k]) terr[k]++;
    if (!nle_s[k]) begin
      if (prev_nle[k]) begin
        if (stable_cnt[k] < s_of(k)) terr[k]++;
        pulses[k]++;
        amask[k][a_s[k]] = 1'b1;
        if (d_s[k]) dmask[k][a_s[k]] = 1'b1;
        low_run[k] = 0;
      end else if (ad_chg) begin
        terr[k]++;
      end
      low_run[k]++;
    end else begin
      if (!prev_nle[k]) begin
        if (low_run[k] != p_of(k)) terr[k]++;
        in_hold[k]  = 1'b1;
        hold_cnt[k] = 0;
      end
      if (ad_chg) begin
        if (in_hold[k] && hold_cnt[k] < h_of(k)) terr[k]++;
        in_hold[k]    = 1'b0;
        stable_cnt[k] = 1;
      end else begin
        stable_cnt[k]++;
        if (in_hold[k]) hold_cnt[k]++;
      end
    end
    prev_a[k]   = a_s[k];
    prev_d[k]   = d_s[k];
    prev_nle[k] = nle_s[k];

    if (busy_s[k]) begin
      busy_cnt[k]++;
    end else if (busy_cnt[k] > 0) begin
      avail = (k == 0) ? q_a.size() : q_b.size();
      check({t, "_exp_available"}, (avail > 0) ? 1 : 0, 1);
      if (avail > 0) begin
        if (k == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        check({t, "_busy_cycles"}, busy_cnt[k], e.busy);
        check({t, "_nle_pulses"}, pulses[k], e.pulses);
        check({t, "_strobe_addrs"}, amask[k], e.amask);
        check({t, "_strobe_d1"}, dmask[k], e.dmask);
        check({t, "_shadow"}, shadow_s[k], e.shadow);
        check({t, "_model_q"}, model_q[k], e.shadow);
        check({t, "_pin_timing_errs"}, terr[k], 0);
      end
      busy_cnt[k] = 0;
      pulses[k]   = 0;
      terr[k]     = 0;
      amask[k]    = 8'h00;
      dmask[k]    = 8'h00;
    end
  endtask

  // Latch model first, then the monitor, both on the quiet edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      model_q[k] = latch_next(model_q[k], a_s[k], d_s[k], nle_s[k], nmr_s[k]);
      mon_step(k);
    end
  end

  task automatic push_exp(input int k, input exp_t e);
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic wait_ready(input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      #2;
      if (wr_ready[k]) got = 1'b1;
    end
    if (!got) check({tag_of(k), "_ready_timeout"}, wr_ready[k], 1);
  endtask

  task automatic do_write(input int k, input logic [7:0] data, input exp_t e);
    wait_ready(k);
    push_exp(k, e);
    wr_data[k]  = data;
    wr_valid[k] = 1'b1;
    @(posedge clk);
    #2;
    wr_valid[k] = 1'b0;
  endtask

  task automatic do_clear(input int k, input logic with_valid, input logic [7:0] data,
                          input exp_t e);
    wait_ready(k);
    push_exp(k, e);
    wr_data[k]  = data;
    wr_valid[k] = with_valid;
    clr_req[k]  = 1'b1;
    @(posedge clk);
    #2;
    clr_req[k]  = 1'b0;
    wr_valid[k] = 1'b0;
    check({tag_of(k), "_clr_ready_low"}, wr_ready[k], 0);
  endtask

  initial begin
    int n_strobe;
    for (int k = 0; k < 2; k++) begin
      nrst[k]     = 1'b0;
      wr_valid[k] = 1'b0;
      wr_data[k]  = 8'h00;
      clr_req[k]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("a_rst_A", a_s[0], 0);
    check("a_rst_nLE", nle_s[0], 1);
    check("a_rst_nMR", nmr_s[0], 0);
    check("a_rst_ready", wr_ready[0], 0);
    check("a_rst_busy", busy_s[0], 1);
    check("a_rst_shadow", shadow_s[0], 8'h00);
    check("b_rst_nMR", nmr_s[1], 0);

    // Release: one nMR cycle on dut_a, three on dut_b.
    push_exp(0, mk(8'h00, 1, 0, 8'h00, 8'h00));
    push_exp(1, mk(8'h00, 3, 0, 8'h00, 8'h00));
    nrst[0] = 1'b1;
    nrst[1] = 1'b1;
    #1;
    check("a_nmr_low_after_release", nmr_s[0], 0);
    @(posedge clk);
    #2;
    check("a_ready_2nd_cycle", wr_ready[0], 1);
    check("a_nmr_high_in_idle", nmr_s[0], 1);

    // Skip-same writes on dut_a.
    do_write(0, 8'hA5, mk(8'hA5, 20, 4, 8'hA5, 8'hA5));
    do_write(0, 8'hA5, mk(8'hA5, 8, 0, 8'h00, 8'h00));
    do_write(0, 8'h5A, mk(8'h5A, 32, 8, 8'hFF, 8'h5A));

    // Clear and write offered together: only the clear happens.
    do_clear(0, 1'b1, 8'h3C, mk(8'h00, 1, 0, 8'h00, 8'h00));

    // Reset during the third strobe of a six-bit write.
    do_write(0, 8'hE7, mk(8'hE7, 26, 6, 8'hE7, 8'hE7));
    n_strobe = 0;
    for (int i = 0; i < 100 && n_strobe < 3; i++) begin
      @(posedge clk);
      #2;
      if (!nle_s[0]) n_strobe++;
    end
    check("a_third_strobe_reached", n_strobe, 3);
    nrst[0] = 1'b0;
    #1;
    check("a_midrst_A", a_s[0], 0);
    check("a_midrst_D", d_s[0], 0);
    check("a_midrst_nLE", nle_s[0], 1);
    check("a_midrst_nMR", nmr_s[0], 0);
    check("a_midrst_ready", wr_ready[0], 0);
    check("a_midrst_shadow", shadow_s[0], 8'h00);
    q_a.delete();
    repeat (2) @(posedge clk);
    #2;
    push_exp(0, mk(8'h00, 1, 0, 8'h00, 8'h00));
    nrst[0] = 1'b1;

    // Edge bits 0 and 7 after the aborted write.
    do_write(0, 8'h81, mk(8'h81, 14, 2, 8'h81, 8'h81));

    // Write-all mode with 2/3/1 timing.
    do_write(1, 8'hFF, mk(8'hFF, 56, 8, 8'hFF, 8'hFF));
    do_write(1, 8'hFF, mk(8'hFF, 56, 8, 8'hFF, 8'hFF));

    for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
